demux_1x4: RTL and testbench

DEMUX_1X4 -- requirements
Module: demux_1x4

---
 rtl/demux_1x4.sv | 96 +++++++++
 tb/tb_demux_1x4.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/demux_1x4.sv
// 1-to-4 registered demultiplexer with one-hot valid. Define DEMUX_1X4_CNT_EN
// to add four saturating per-channel routing counters with clear and readout.
module demux_1x4 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [1:0]       s,
    input  logic             en,
`ifdef DEMUX_1X4_CNT_EN
    input  logic             cnt_clr,
    input  logic [1:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_out,
`endif
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [3:0]       vld
);

    logic [WIDTH-1:0] y0_d, y1_d, y2_d, y3_d;
    logic [WIDTH-1:0] y0_q, y1_q, y2_q, y3_q;
    logic [3:0]       vld_d, vld_q;

    // s is only decoded under en, so an unknown select while idle cannot leak out.
    always_comb begin
        y0_d  = '0;
        y1_d  = '0;
        y2_d  = '0;
        y3_d  = '0;
        vld_d = 4'b0000;
        if (en) begin
            case (s)
                2'd0:    begin y0_d = a; vld_d = 4'b0001; end
                2'd1:    begin y1_d = a; vld_d = 4'b0010; end
                2'd2:    begin y2_d = a; vld_d = 4'b0100; end
                default: begin y3_d = a; vld_d = 4'b1000; end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y0_q  <= '0;
            y1_q  <= '0;
            y2_q  <= '0;
            y3_q  <= '0;
            vld_q <= 4'b0000;
        end else begin
            y0_q  <= y0_d;
            y1_q  <= y1_d;
            y2_q  <= y2_d;
            y3_q  <= y3_d;
            vld_q <= vld_d;
        end
    end

    assign y0  = y0_q;
    assign y1  = y1_q;
    assign y2  = y2_q;
    assign y3  = y3_q;
    assign vld = vld_q;

`ifdef DEMUX_1X4_CNT_EN
    logic [CNT_W-1:0] cnt_d [4];
    logic [CNT_W-1:0] cnt_q [4];

    // Clear beats increment; a full counter holds instead of wrapping.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            cnt_d[k] = cnt_q[k];
            if (cnt_clr) begin
                cnt_d[k] = '0;
            end else if (en && (s == 2'(k)) && (cnt_q[k] != {CNT_W{1'b1}})) begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                cnt_q[k] <= '0;
            end else begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign cnt_out = cnt_q[cnt_sel];
`endif

endmodule

// File: tb/tb_demux_1x4.sv
// Directed bench for demux_1x4 (WIDTH=1, CNT_W=2); counter checks are
// compiled in when DEMUX_1X4_CNT_EN is defined.
module tb_demux_1x4;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:0] a;
    logic [1:0] s;
    logic       en;
    logic [0:0] y0, y1, y2, y3;
    logic [3:0] vld;
`ifdef DEMUX_1X4_CNT_EN
    logic       cnt_clr;
    logic [1:0] cnt_sel;
    logic [1:0] cnt_out;
`endif

    int checks = 0;
    int errors = 0;

    demux_1x4 #(.WIDTH(1), .CNT_W(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .s       (s),
        .en      (en),
`ifdef DEMUX_1X4_CNT_EN
        .cnt_clr (cnt_clr),
        .cnt_sel (cnt_sel),
        .cnt_out (cnt_out),
`endif
        .y0      (y0),
        .y1      (y1),
        .y2      (y2),
        .y3      (y3),
        .vld     (vld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then sample away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] exp_y, input logic [3:0] exp_v);
        chk({tag, "_y"}, {28'd0, y3, y2, y1, y0}, {28'd0, exp_y});
        chk({tag, "_vld"}, {28'd0, vld}, {28'd0, exp_v});
    endtask

`ifdef DEMUX_1X4_CNT_EN
    task automatic chk_cnt(input string tag, input logic [1:0] sel, input logic [1:0] exp);
        cnt_sel = sel;
        #1;
        chk(tag, {30'd0, cnt_out}, {30'd0, exp});
    endtask
`endif

    initial begin
        rst = 1'b1; en = 1'b0; a = 1'b0; s = 2'd0;
`ifdef DEMUX_1X4_CNT_EN
        cnt_clr = 1'b0; cnt_sel = 2'd0;
`endif
        tick();
        tick();
        chk_out("reset", 4'b0000, 4'b0000);
        rst = 1'b0;
        tick();
        chk_out("idle_after_rst", 4'b0000, 4'b0000);
`ifdef DEMUX_1X4_CNT_EN
        for (int k = 0; k < 4; k++) chk_cnt("cnt_after_rst", 2'(k), 2'd0);
`endif

        // routed zeros: data stays 0, valid marks the channel
        en = 1'b1; a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s = 2'(k);
            tick();
            chk_out("zero_route", 4'b0000, 4'(1 << k));
        end

        // routed ones sweeping the select
        a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s = 2'(k);
            tick();
            chk_out("one_route", 4'(1 << k), 4'(1 << k));
        end
`ifdef DEMUX_1X4_CNT_EN
        for (int k = 0; k < 4; k++) chk_cnt("cnt_two_each", 2'(k), 2'd2);
`endif

        // reset overrides an active route
        s = 2'd2;
        tick();
        chk_out("pre_rst_s2", 4'b0100, 4'b0100);
        rst = 1'b1; s = 2'd3;
        tick();
        chk_out("rst_override", 4'b0000, 4'b0000);
`ifdef DEMUX_1X4_CNT_EN
        for (int k = 0; k < 4; k++) chk_cnt("cnt_rst_clear", 2'(k), 2'd0);
`endif
        // nothing captured during reset appears afterwards
        rst = 1'b0; en = 1'b0;
        tick();
        chk_out("post_rst_idle", 4'b0000, 4'b0000);

        // back-to-back select change: single valid each cycle
        en = 1'b1; a = 1'b1; s = 2'd1;
        tick();
        chk_out("resume_s1", 4'b0010, 4'b0010);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_out("repeat_s1", 4'b0010, 4'b0010);
        end
`ifdef DEMUX_1X4_CNT_EN
        chk_cnt("cnt_sat_s1", 2'd1, 2'd3);
        chk_cnt("cnt_s0_untouched", 2'd0, 2'd0);
`endif
        s = 2'd3;
        tick();
        chk_out("switch_s3", 4'b1000, 4'b1000);

        // disabled: nothing routed regardless of a and s
        en = 1'b0; a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s = 2'(k);
            tick();
            chk_out("disabled", 4'b0000, 4'b0000);
        end
        s = 2'bxx;
        tick();
        chk_out("disabled_s_x", 4'b0000, 4'b0000);
`ifdef DEMUX_1X4_CNT_EN
        chk_cnt("cnt_hold_s1", 2'd1, 2'd3);
        chk_cnt("cnt_hold_s3", 2'd3, 2'd1);

        // clear coincides with an increment: clear wins
        en = 1'b1; s = 2'd3; cnt_clr = 1'b1;
        tick();
        chk_out("clr_route_s3", 4'b1000, 4'b1000);
        chk_cnt("cnt_clr_wins", 2'd3, 2'd0);
        chk_cnt("cnt_clr_s1", 2'd1, 2'd0);
        cnt_clr = 1'b0;
        tick();
        chk_cnt("cnt_after_clr", 2'd3, 2'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
